// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants, maximal-length tap table and step function
package lfsr_pkg;

  localparam int unsigned    LFSR_DEF_WIDTH = 5;
  localparam logic [4:0]     LFSR_DEF_TAPS  = 5'b00101;
  localparam logic [4:0]     LFSR_DEF_SEED  = 5'b00001;

  // Masks for the right-shifting form: bit i set means state[i] feeds the XOR.
  function automatic logic [31:0] lfsr_table_taps(input int unsigned width);
    logic [31:0] taps;
    taps = 32'h0;
    case (width)
      3:  taps = 32'h0000_0003;
      4:  taps = 32'h0000_0003;
      5:  taps = 32'h0000_0005;
      6:  taps = 32'h0000_0003;
      7:  taps = 32'h0000_0003;
      8:  taps = 32'h0000_001D;
      9:  taps = 32'h0000_0011;
      10: taps = 32'h0000_0009;
      11: taps = 32'h0000_0005;
      12: taps = 32'h0000_0941;
      13: taps = 32'h0000_1601;
      14: taps = 32'h0000_2A01;
      15: taps = 32'h0000_0003;
      16: taps = 32'h0000_100B;
      17: taps = 32'h0000_0009;
      18: taps = 32'h0000_0081;
      19: taps = 32'h0006_2001;
      20: taps = 32'h0000_0009;
      21: taps = 32'h0000_0005;
      22: taps = 32'h0000_0003;
      23: taps = 32'h0000_0021;
      24: taps = 32'h0000_0087;
      25: taps = 32'h0000_0009;
      26: taps = 32'h0310_0001;
      27: taps = 32'h0640_0001;
      28: taps = 32'h0000_0009;
      29: taps = 32'h0000_0005;
      30: taps = 32'h2500_0001;
      31: taps = 32'h0000_0009;
      32: taps = 32'hC000_0401;
      default: taps = 32'h0;
    endcase
    return taps;
  endfunction

  // One plain Fibonacci step; the all-zero lock-up guard is left to the caller.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int unsigned width = LFSR_DEF_WIDTH);
    logic [31:0] mask;
    logic [31:0] s;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    s    = state & mask;
    fb   = ^(s & taps);
    return (s >> 1) | (32'(fb) << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr5_gen.sv
// rtl/lfsr5_gen.sv - free-running Fibonacci LFSR, right shift with feedback into the MSB
module lfsr5_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_table_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] lfsr
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr5_gen: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr5_gen: SEED must be nonzero");
  end
  if (TAPS[0] != 1'b1) begin : g_bad_taps
    $error("lfsr5_gen: TAPS[0] must be set");
  end

  // Initialiser gives a valid state from power-up even if reset never asserts.
  logic [WIDTH-1:0] r_lfsr = SEED;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;

  assign w_fb   = ^(r_lfsr & TAPS);
  assign w_next = {w_fb, r_lfsr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset || (r_lfsr == '0)) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign lfsr = r_lfsr;

endmodule

// File: tb/tb_lfsr5_gen.sv
// tb/tb_lfsr5_gen.sv - scoreboard bench for lfsr5_gen against a period-table model
module tb_lfsr5_gen;
  import lfsr_pkg::*;

  localparam int PERIOD = 31;

  typedef struct {
    logic [4:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] lfsr;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [4:0] obs[$];
  bit         rec = 1'b0;
  string      phase = "init";

  logic [4:0] seq[PERIOD];
  int         p = 0;

  lfsr5_gen dut (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  always #5 clk = ~clk;

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  exp_t e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (lfsr !== e.val) begin
        errors++;
        $display("FAIL %s: lfsr=%b expected=%b at %0t", e.tag, lfsr, e.val, $time);
      end
      if (rec) obs.push_back(lfsr);
    end
  end

  function automatic logic [4:0] model_val(input int idx);
    return (idx < 0) ? 5'b00000 : seq[idx];
  endfunction

  // Drive reset for one edge and predict the value that edge produces.
  task automatic tick(input logic rst, input int ovr = -1);
    exp_t x;
    reset = rst;
    @(posedge clk);
    #1;
    if (rst || p < 0) p = 0;
    else p = (p + 1) % PERIOD;
    x.val = (ovr >= 0) ? 5'(ovr) : model_val(p);
    x.tag = phase;
    sb.push_back(x);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] s;
    logic [4:0] first6 [6];
    bit         seen [32];
    int         uniq;
    int         first_one;
    logic [31:0] nx;

    // Period table built from the polynomial: new MSB = bit0 xor bit2.
    s = 5'b00001;
    for (int i = 0; i < PERIOD; i++) begin
      seq[i] = s;
      s = {s[0] ^ s[2], s[4:1]};
    end
    first6 = '{5'b10000, 5'b01000, 5'b00100, 5'b10010, 5'b01001, 5'b10100};

    // Package step function must agree with the table over a full period.
    uniq = 0;
    for (int i = 0; i < PERIOD; i++) begin
      nx = lfsr_next(32'(seq[i]), 32'(LFSR_DEF_TAPS), 5);
      if (nx[4:0] != seq[(i + 1) % PERIOD]) uniq++;
    end
    checks++;
    if (uniq != 0) begin
      errors++;
      $display("FAIL pkg_next: %0d steps disagree expected=0", uniq);
    end

    // No-reset start: output valid from time zero.
    #1;
    checks++;
    if (lfsr !== 5'b00001) begin
      errors++;
      $display("FAIL powerup: lfsr=%b expected=00001", lfsr);
    end

    // Period: 35 free-running clocks from power-up seed.
    phase = "period";
    rec = 1'b1;
    for (int i = 0; i < 35; i++) tick(1'b0);
    settle();
    rec = 1'b0;

    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    uniq = 0;
    first_one = -1;
    for (int i = 0; i < obs.size(); i++) begin
      if (i < PERIOD && obs[i] !== 5'bxxxxx && !seen[obs[i]]) begin
        seen[obs[i]] = 1'b1;
        uniq++;
      end
      if (first_one < 0 && obs[i] === 5'b00001) first_one = i + 1;
    end
    checks++;
    if (obs.size() != 35) begin
      errors++;
      $display("FAIL period_samples: got=%0d expected=35", obs.size());
    end
    checks++;
    if (first_one != 31) begin
      errors++;
      $display("FAIL period_recur: seed recurs at clock %0d expected=31", first_one);
    end
    checks++;
    if (uniq != 31 || seen[0]) begin
      errors++;
      $display("FAIL period_unique: distinct=%0d zero_seen=%0d expected=31/0", uniq, seen[0]);
    end

    // Reset for two edges from an arbitrary state, then hold.
    phase = "reset";
    tick(1'b1);
    tick(1'b1);
    phase = "reset_hold";
    for (int i = 0; i < 3; i++) tick(1'b1);

    // First six values after release, against literal constants.
    phase = "first6";
    for (int i = 0; i < 6; i++) tick(1'b0, int'(first6[i]));
    phase = "seq";
    for (int i = 0; i < 6; i++) tick(1'b0);

    // Mid-run reset on clock 13 after a fresh start.
    phase = "mid_start";
    tick(1'b1);
    phase = "mid_run";
    for (int i = 0; i < 12; i++) tick(1'b0);
    phase = "mid_reset";
    tick(1'b1);
    phase = "mid_restart";
    for (int i = 0; i < 8; i++) tick(1'b0);

    // Lock-up: hold the register at zero across one edge, then release.
    settle();
    force dut.r_lfsr = 5'b00000;
    @(posedge clk);
    #1;
    p = -1;
    sb.push_back('{val: 5'b00000, tag: "lockup_zero"});
    settle();
    release dut.r_lfsr;
    phase = "lockup_recover";
    tick(1'b0);
    phase = "lockup_run";
    for (int i = 0; i < 4; i++) tick(1'b0);

    // Randomised reset pattern.
    phase = "random";
    for (int i = 0; i < 300; i++) tick($urandom_range(0, 15) == 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) settle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
